// File: rtl/seven_segment_capture.sv
// Captures a multiplexed 4-digit seven-segment bus, filters digit-switch ghosting
// and republishes the settled digits as a 4-digit BCD frame.
module seven_segment_capture #(
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg,
  input  logic [3:0]  digit_sel,
  output logic [15:0] bcd,
  output logic        frame_valid,
  output logic        frame_err,
  output logic [3:0]  seen,
  output logic        stale
);

  localparam logic [7:0]  STABLE_C    = 8'(STABLE_CYCLES);
  localparam logic [23:0] TIMEOUT_C   = 24'(TIMEOUT);
  localparam logic [23:0] STALE_MAX_C = 24'hFF_FFFF;

  // Returns {error, nibble}; blank is a legal "no digit" code, anything unknown is E.
  function automatic logic [4:0] decode_seg(input logic [6:0] pattern);
    logic [4:0] result;
    case (pattern)
      7'b1111110: result = 5'b0_0000;
      7'b0110000: result = 5'b0_0001;
      7'b1101101: result = 5'b0_0010;
      7'b1111001: result = 5'b0_0011;
      7'b0110011: result = 5'b0_0100;
      7'b1011011: result = 5'b0_0101;
      7'b1011111: result = 5'b0_0110;
      7'b1110000: result = 5'b0_0111;
      7'b1111111: result = 5'b0_1000;
      7'b1111011: result = 5'b0_1001;
      7'b0000000: result = 5'b0_1111;
      default:    result = 5'b1_1110;
    endcase
    return result;
  endfunction

  function automatic logic is_one_hot(input logic [3:0] sel);
    return (sel != 4'b0000) && ((sel & (sel - 4'b0001)) == 4'b0000);
  endfunction

  logic [10:0] sample_r;
  logic [7:0]  run_r;
  logic [15:0] shadow_r;
  logic        err_acc_r;
  logic [23:0] stale_cnt_r;

  logic [10:0] sample_s;
  logic        same_s;
  logic        one_hot_s;
  logic [7:0]  run_nxt_s;
  logic        accept_s;
  logic [4:0]  dec_s;
  logic        complete_s;
  logic [3:0]  seen_nxt_s;
  logic        err_nxt_s;
  logic [15:0] shadow_nxt_s;
  logic [23:0] stale_nxt_s;

  // Run-length tracking against the previous sample, accept detection and next-frame state.
  always_comb begin
    sample_s  = {seg, digit_sel};
    same_s    = (sample_s == sample_r);
    one_hot_s = is_one_hot(digit_sel);
    run_nxt_s = 8'd0;
    if (one_hot_s && same_s) begin
      if (run_r >= STABLE_C) begin
        run_nxt_s = STABLE_C;
      end else begin
        run_nxt_s = run_r + 8'd1;
      end
    end else if (one_hot_s) begin
      run_nxt_s = 8'd1;
    end else begin
      run_nxt_s = 8'd0;
    end
    // A run already saturated at STABLE_CYCLES must not re-fire.
    accept_s     = one_hot_s && (run_nxt_s == STABLE_C) && !(same_s && (run_r == STABLE_C));
    dec_s        = decode_seg(seg);
    complete_s   = (seen == 4'b1111);
    seen_nxt_s   = (complete_s ? 4'b0000 : seen) | (accept_s ? digit_sel : 4'b0000);
    err_nxt_s    = (complete_s ? 1'b0 : err_acc_r) | (accept_s & dec_s[4]);
    shadow_nxt_s = shadow_r;
    for (int i = 0; i < 4; i++) begin
      if (accept_s && digit_sel[i]) begin
        shadow_nxt_s[4*i +: 4] = dec_s[3:0];
      end else begin
        shadow_nxt_s[4*i +: 4] = shadow_r[4*i +: 4];
      end
    end
    if (accept_s) begin
      stale_nxt_s = 24'd0;
    end else if (stale_cnt_r == STALE_MAX_C) begin
      stale_nxt_s = stale_cnt_r;
    end else begin
      stale_nxt_s = stale_cnt_r + 24'd1;
    end
  end

  // Sample, run, shadow and stale registers plus the registered frame outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_r    <= 11'd0;
      run_r       <= 8'd0;
      shadow_r    <= 16'h0000;
      err_acc_r   <= 1'b0;
      stale_cnt_r <= 24'd0;
      bcd         <= 16'hFFFF;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      seen        <= 4'b0000;
      stale       <= 1'b0;
    end else begin
      sample_r    <= sample_s;
      run_r       <= run_nxt_s;
      shadow_r    <= shadow_nxt_s;
      err_acc_r   <= err_nxt_s;
      stale_cnt_r <= stale_nxt_s;
      seen        <= seen_nxt_s;
      stale       <= (stale_nxt_s >= TIMEOUT_C);
      frame_valid <= complete_s;
      if (complete_s) begin
        bcd       <= shadow_r;
        frame_err <= err_acc_r;
      end else begin
        bcd       <= bcd;
        frame_err <= frame_err;
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_capture.sv
// Scoreboard bench for seven_segment_capture (STABLE_CYCLES=4, TIMEOUT=100).
module tb_seven_segment_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg;
  logic [3:0]  digit_sel;
  logic [15:0] bcd;
  logic        frame_valid;
  logic        frame_err;
  logic [3:0]  seen;
  logic        stale;

  localparam logic [6:0] P0 = 7'b1111110, P1 = 7'b0110000, P2 = 7'b1101101,
                         P3 = 7'b1111001, P4 = 7'b0110011, P5 = 7'b1011011,
                         P6 = 7'b1011111, P7 = 7'b1110000, P8 = 7'b1111111,
                         P9 = 7'b1111011, PBLANK = 7'b0000000, PBAD = 7'b1010101;

  int checks_total  = 0;
  int checks_passed = 0;
  int fv_cnt        = 0;
  logic [16:0] exp_q[$];
  logic [16:0] got_q[$];

  seven_segment_capture #(.STABLE_CYCLES(4), .TIMEOUT(100)) dut (
    .clk(clk), .rst(rst), .seg(seg), .digit_sel(digit_sel), .bcd(bcd),
    .frame_valid(frame_valid), .frame_err(frame_err), .seen(seen), .stale(stale)
  );

  always #5 clk = ~clk;

  // Frame monitor: records every published frame as {frame_err, bcd}.
  always @(posedge clk) begin
    #2;
    if (frame_valid === 1'b1) begin
      got_q.push_back({frame_err, bcd});
      fv_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; holds the inputs for n rising edges, returns at a negedge.
  task automatic drive(input logic [3:0] sel, input logic [6:0] pat, input int n);
    digit_sel = sel;
    seg       = pat;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_frames(input string name);
    logic [16:0] e, g;
    for (int i = 0; i < 20 && got_q.size() < exp_q.size(); i++) @(negedge clk);
    checks_total++;
    if (got_q.size() !== exp_q.size()) begin
      $display("FAIL %s frame_count got=%0d want=%0d", name, got_q.size(), exp_q.size());
      exp_q.delete();
      got_q.delete();
    end else begin
      checks_passed++;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = got_q.pop_front();
        checks_total++;
        if (g !== e) $display("FAIL %s frame got err=%0b bcd=%h want err=%0b bcd=%h", name, g[16], g[15:0], e[16], e[15:0]);
        else checks_passed++;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    seg = 7'd0;
    digit_sel = 4'd0;
    repeat (3) @(negedge clk);
    checks_total += 5;
    if (bcd !== 16'hFFFF) $display("FAIL reset_bcd got=%h want=ffff", bcd); else checks_passed++;
    if (frame_valid !== 1'b0) $display("FAIL reset_fv got=%b want=0", frame_valid); else checks_passed++;
    if (frame_err !== 1'b0) $display("FAIL reset_err got=%b want=0", frame_err); else checks_passed++;
    if (seen !== 4'b0000) $display("FAIL reset_seen got=%b want=0000", seen); else checks_passed++;
    if (stale !== 1'b0) $display("FAIL reset_stale got=%b want=0", stale); else checks_passed++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_frame;
    exp_q.push_back({1'b0, 16'h4321});
    drive(4'b0001, P1, 8);
    drive(4'b0010, P2, 8);
    drive(4'b0100, P3, 8);
    drive(4'b1000, P4, 8);
    drive(4'b0000, PBLANK, 3);
    check_frames("basic");
    checks_total++;
    if (seen !== 4'b0000) $display("FAIL basic_seen got=%b want=0000", seen); else checks_passed++;
  endtask

  task automatic test_latency;
    drive(4'b0001, P1, 3);
    drive(4'b0000, PBLANK, 2);
    checks_total++;
    if (seen !== 4'b0000) $display("FAIL short_run_seen got=%b want=0000", seen); else checks_passed++;
    drive(4'b0001, P1, 4);
    checks_total++;
    if (seen !== 4'b0001) $display("FAIL hold4_seen got=%b want=0001", seen); else checks_passed++;
    exp_q.push_back({1'b0, 16'h9321});
    drive(4'b0010, P2, 8);
    drive(4'b0100, P3, 8);
    drive(4'b1000, P9, 3);
    checks_total++;
    if (seen !== 4'b0111) $display("FAIL lat_seen_e2 got=%b want=0111", seen); else checks_passed++;
    @(negedge clk);
    checks_total += 2;
    if (seen !== 4'b1111) $display("FAIL lat_seen_e3 got=%b want=1111", seen); else checks_passed++;
    if (frame_valid !== 1'b0) $display("FAIL lat_fv_e3 got=%b want=0", frame_valid); else checks_passed++;
    @(negedge clk);
    checks_total += 2;
    if (frame_valid !== 1'b1) $display("FAIL lat_fv_e4 got=%b want=1", frame_valid); else checks_passed++;
    if (seen !== 4'b0000) $display("FAIL lat_seen_e4 got=%b want=0000", seen); else checks_passed++;
    @(negedge clk);
    checks_total++;
    if (frame_valid !== 1'b0) $display("FAIL lat_fv_pulse got=%b want=0", frame_valid); else checks_passed++;
    drive(4'b0000, PBLANK, 2);
    check_frames("latency");
  endtask

  task automatic test_error_frame;
    exp_q.push_back({1'b1, 16'hEF80});
    drive(4'b0001, P0, 6);
    drive(4'b0010, P8, 6);
    drive(4'b0100, PBLANK, 6);
    drive(4'b1000, PBAD, 6);
    drive(4'b0000, PBLANK, 3);
    check_frames("error");
    exp_q.push_back({1'b0, 16'h0765});
    drive(4'b0001, P5, 6);
    drive(4'b0010, P6, 6);
    drive(4'b0100, P7, 6);
    drive(4'b1000, P0, 6);
    drive(4'b0000, PBLANK, 3);
    check_frames("error_clear");
  endtask

  task automatic test_stale;
    drive(4'b0001, P5, 4);
    drive(4'b0000, PBLANK, 99);
    checks_total++;
    if (stale !== 1'b0) $display("FAIL stale_99 got=%b want=0", stale); else checks_passed++;
    @(negedge clk);
    checks_total++;
    if (stale !== 1'b1) $display("FAIL stale_100 got=%b want=1", stale); else checks_passed++;
    drive(4'b0010, P6, 3);
    checks_total++;
    if (stale !== 1'b1) $display("FAIL stale_before_accept got=%b want=1", stale); else checks_passed++;
    @(negedge clk);
    checks_total += 2;
    if (stale !== 1'b0) $display("FAIL stale_after_accept got=%b want=0", stale); else checks_passed++;
    if (seen !== 4'b0011) $display("FAIL stale_seen got=%b want=0011", seen); else checks_passed++;
  endtask

  task automatic test_reset_mid_frame;
    int fv_before;
    fv_before = fv_cnt;
    rst = 1'b1;
    digit_sel = 4'b0000;
    seg = PBLANK;
    @(negedge clk);
    checks_total += 2;
    if (seen !== 4'b0000) $display("FAIL mid_rst_seen got=%b want=0000", seen); else checks_passed++;
    if (bcd !== 16'hFFFF) $display("FAIL mid_rst_bcd got=%h want=ffff", bcd); else checks_passed++;
    rst = 1'b0;
    drive(4'b0000, PBLANK, 4);
    checks_total++;
    if (fv_cnt !== fv_before) $display("FAIL mid_rst_no_frame got=%0d want=%0d", fv_cnt, fv_before); else checks_passed++;
    exp_q.push_back({1'b0, 16'h4321});
    drive(4'b0001, P1, 6);
    drive(4'b0010, P2, 6);
    drive(4'b0100, P3, 6);
    drive(4'b1000, P4, 6);
    drive(4'b0000, PBLANK, 3);
    check_frames("after_reset");
  endtask

  task automatic test_overwrite;
    drive(4'b0011, P8, 20);
    checks_total++;
    if (seen !== 4'b0000) $display("FAIL multi_hot_seen got=%b want=0000", seen); else checks_passed++;
    exp_q.push_back({1'b0, 16'h1072});
    drive(4'b0010, P5, 8);
    drive(4'b0000, PBLANK, 2);
    drive(4'b0010, P7, 8);
    drive(4'b0001, P2, 8);
    drive(4'b0100, P0, 8);
    drive(4'b1000, P1, 8);
    drive(4'b0000, PBLANK, 3);
    check_frames("overwrite");
  endtask

  task automatic test_back_to_back;
    exp_q.push_back({1'b0, 16'h6789});
    exp_q.push_back({1'b0, 16'h3210});
    drive(4'b0001, P9, 4);
    drive(4'b0010, P8, 4);
    drive(4'b0100, P7, 4);
    drive(4'b1000, P6, 4);
    drive(4'b0001, P0, 4);
    drive(4'b0010, P1, 4);
    drive(4'b0100, P2, 4);
    drive(4'b1000, P3, 4);
    drive(4'b0000, PBLANK, 3);
    check_frames("back_to_back");
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic_frame();
    test_latency();
    test_error_frame();
    test_stale();
    test_reset_mid_frame();
    test_overwrite();
    test_back_to_back();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
